// File: rtl/dispense_controller.sv
// rtl/dispense_controller.sv - valve dispense cycle: timed countdown with pause/resume/abort on OK/CANCEL edges
module dispense_controller #(
  parameter int TIME_WIDTH     = 32,
  parameter int MAX_TIME       = 9999,
  parameter int TICKS_PER_UNIT = 50_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [TIME_WIDTH-1:0] total_time,
  input  logic                  button_ok,
  input  logic                  button_cancel,
  output logic                  valve_open,
  output logic [TIME_WIDTH-1:0] remaining_time,
  output logic                  busy,
  output logic                  done,
  output logic                  clear_entry
);

  localparam int PW = (TICKS_PER_UNIT > 2) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0]         LAST_TICK = PW'(TICKS_PER_UNIT - 1);
  localparam logic [TIME_WIDTH-1:0] MAX_T     = TIME_WIDTH'(MAX_TIME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPENSING,
    S_PAUSED,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [TIME_WIDTH-1:0]   remaining_q, remaining_d;
  logic                    clear_q, clear_d;
  logic                    ok_prev_q, cancel_prev_q;
  logic                    ok_ev, cancel_ev, tick;

  // CANCEL dominates a simultaneous OK press
  assign cancel_ev = button_cancel & ~cancel_prev_q;
  assign ok_ev     = button_ok & ~ok_prev_q & ~cancel_ev;
  assign tick      = (prescaler_q == LAST_TICK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      prescaler_q   <= '0;
      remaining_q   <= '0;
      clear_q       <= 1'b0;
      ok_prev_q     <= 1'b0;
      cancel_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      remaining_q   <= remaining_d;
      clear_q       <= clear_d;
      ok_prev_q     <= button_ok;
      cancel_prev_q <= button_cancel;
    end
  end

  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    remaining_d = remaining_q;
    clear_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ok_ev && (total_time != '0)) begin
          state_d     = S_DISPENSING;
          remaining_d = (total_time > MAX_T) ? MAX_T : total_time;
          prescaler_d = '0;
          clear_d     = 1'b1;
        end
      end
      S_DISPENSING: begin
        // The final tick beats a CANCEL on the same edge; otherwise CANCEL freezes the count
        if (tick && (remaining_q <= TIME_WIDTH'(1))) begin
          state_d     = S_DONE;
          remaining_d = '0;
          prescaler_d = '0;
        end else if (cancel_ev) begin
          state_d = S_PAUSED;
        end else if (tick) begin
          prescaler_d = '0;
          remaining_d = remaining_q - TIME_WIDTH'(1);
        end else begin
          prescaler_d = prescaler_q + PW'(1);
        end
      end
      S_PAUSED: begin
        if (cancel_ev) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          prescaler_d = '0;
          clear_d     = 1'b1;
        end else if (ok_ev) begin
          state_d = S_DISPENSING;
        end
      end
      S_DONE: begin
        remaining_d = '0;
        if (ok_ev || cancel_ev) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        remaining_d = '0;
        prescaler_d = '0;
      end
    endcase
  end

  assign valve_open     = (state_q == S_DISPENSING);
  assign busy           = (state_q == S_DISPENSING) || (state_q == S_PAUSED);
  assign done           = (state_q == S_DONE);
  assign remaining_time = remaining_q;
  assign clear_entry    = clear_q;

endmodule

// File: tb/tb_dispense_controller.sv
// tb/tb_dispense_controller.sv - scoreboard bench for dispense_controller with TICKS_PER_UNIT=4
module tb_dispense_controller;

  logic        clock;
  logic        reset;
  logic [31:0] total_time;
  logic        button_ok;
  logic        button_cancel;
  logic        valve_open;
  logic [31:0] remaining_time;
  logic        busy;
  logic        done;
  logic        clear_entry;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ok;
    logic        cancel;
    logic [31:0] tt;
    logic [35:0] exp;
  } step_t;

  step_t sb_q[$];

  dispense_controller #(
    .TIME_WIDTH    (32),
    .MAX_TIME      (9999),
    .TICKS_PER_UNIT(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .total_time    (total_time),
    .button_ok     (button_ok),
    .button_cancel (button_cancel),
    .valve_open    (valve_open),
    .remaining_time(remaining_time),
    .busy          (busy),
    .done          (done),
    .clear_entry   (clear_entry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {valve_open, busy, done, clear_entry, remaining_time}
  wire [35:0] obs = {valve_open, busy, done, clear_entry, remaining_time};

  function automatic logic [35:0] e_idle(input logic c);
    return {1'b0, 1'b0, 1'b0, c, 32'd0};
  endfunction
  function automatic logic [35:0] e_disp(input logic [31:0] r, input logic c);
    return {1'b1, 1'b1, 1'b0, c, r};
  endfunction
  function automatic logic [35:0] e_paus(input logic [31:0] r);
    return {1'b0, 1'b1, 1'b0, 1'b0, r};
  endfunction
  function automatic logic [35:0] e_done();
    return {1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
  endfunction

  // Queue one cycle of stimulus together with the outputs required after its clock edge
  function automatic void add(input logic ok, input logic cancel, input logic [31:0] tt,
                              input logic [35:0] exp);
    step_t s;
    s.ok = ok; s.cancel = cancel; s.tt = tt; s.exp = exp;
    sb_q.push_back(s);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step_t s;
    reset = 1'b0; total_time = '0; button_ok = 1'b0; button_cancel = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 36'd0);
    end
    reset = 1'b1;
    add(0, 0, 0, e_idle(0));
    add(0, 1, 0, e_idle(0));
    add(0, 0, 0, e_idle(0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL idle_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_basic();
    step_t s;
    add(1, 0, 3, e_disp(3, 1));
    for (int k = 1; k < 12; k++) add(0, 0, 3, e_disp(32'(3 - k / 4), 0));
    add(0, 0, 3, e_done());
    add(0, 0, 3, e_done());
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL basic_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_done_exit();
    step_t s;
    add(1, 0, 0, e_idle(0));
    add(0, 0, 1, e_idle(0));
    add(1, 0, 1, e_disp(1, 1));
    for (int k = 1; k < 4; k++) add(0, 0, 1, e_disp(1, 0));
    add(0, 0, 1, e_done());
    add(1, 0, 1, e_idle(0));
    add(0, 0, 1, e_idle(0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL done_exit_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_pause_resume();
    step_t s;
    add(1, 0, 2, e_disp(2, 1));
    for (int k = 1; k <= 5; k++) add(0, 0, 2, e_disp((k < 4) ? 32'd2 : 32'd1, 0));
    add(0, 1, 2, e_paus(1));
    for (int k = 0; k < 20; k++) add(0, 0, 9, e_paus(1));
    add(1, 0, 9, e_disp(1, 0));
    add(0, 0, 9, e_disp(1, 0));
    add(0, 0, 9, e_disp(1, 0));
    add(0, 0, 9, e_done());
    add(1, 0, 9, e_idle(0));
    add(0, 0, 9, e_idle(0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL pause_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_abort();
    step_t s;
    add(1, 0, 3, e_disp(3, 1));
    add(0, 1, 3, e_paus(3));
    add(0, 0, 3, e_paus(3));
    add(0, 1, 3, e_idle(1));
    add(0, 0, 3, e_idle(0));
    add(1, 0, 0, e_idle(0));
    add(0, 0, 0, e_idle(0));
    add(0, 0, 0, e_idle(0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL abort_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_edge_cases();
    step_t s;
    add(1, 0, 12345, e_disp(9999, 1));
    add(0, 0, 7, e_disp(9999, 0));
    add(0, 1, 7, e_paus(9999));
    add(0, 0, 7, e_paus(9999));
    add(1, 1, 7, e_idle(1));
    add(0, 0, 2, e_idle(0));
    for (int k = 0; k < 10; k++)
      add(1, 0, 2, (k >= 8) ? e_done() : e_disp((k < 4) ? 32'd2 : 32'd1, (k == 0)));
    add(0, 0, 2, e_done());
    add(1, 0, 2, e_idle(0));
    add(0, 0, 1, e_idle(0));
    add(1, 0, 1, e_disp(1, 1));
    for (int k = 1; k < 4; k++) add(0, 0, 1, e_disp(1, 0));
    add(0, 1, 1, e_done());
    add(0, 0, 1, e_done());
    add(1, 0, 1, e_idle(0));
    add(0, 0, 1, e_idle(0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL edge_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    step_t s;
    add(1, 0, 5, e_disp(5, 1));
    add(0, 0, 5, e_disp(5, 0));
    add(0, 0, 5, e_disp(5, 0));
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      button_ok = s.ok; button_cancel = s.cancel; total_time = s.tt;
      tick();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL reset_mid_step%0d: got %h expected %h", i, obs, s.exp);
      end
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, 36'd0);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== e_idle(0)) begin
      errors++;
      $display("FAIL after_reset_idle: got %h expected %h", obs, e_idle(0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_exit();
    test_pause_resume();
    test_abort();
    test_edge_cases();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
